// File: rtl/matrix_result_drain_if.sv
// ----------------------------------------------------------------------------
// matrix_result_drain_if
// Bundles the two streaming ports of matrix_result_drain.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// where valid and ready are both high. Once valid is raised, the producer
// holds valid and its payload stable until that transfer. Ready may change
// freely.
//
//   Input channel  (multiplier -> drain) : in_valid, in_ready, in_data, in_ovf
//   Output channel (drain -> mem writer) : out_valid, out_ready, out_data,
//                                          out_addr, out_last, out_ovf
//
// Modports: master = the multiplier side that feeds matrices and consumes
// elements (the bench); slave = the drain block itself.
// ----------------------------------------------------------------------------
interface matrix_result_drain_if #(
   parameter int DW = 16,
   parameter int N  = 4,
   parameter int AW = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [N*N*DW-1:0]     in_data;
   logic [N*N-1:0]        in_ovf;
   logic                  out_valid;
   logic                  out_ready;
   logic [DW-1:0]         out_data;
   logic [AW-1:0]         out_addr;
   logic                  out_last;
   logic                  out_ovf;

   modport master (
      output in_valid, in_data, in_ovf, out_ready,
      input  in_ready, out_valid, out_data, out_addr, out_last, out_ovf
   );

   modport slave (
      input  in_valid, in_data, in_ovf, out_ready,
      output in_ready, out_valid, out_data, out_addr, out_last, out_ovf
   );
endinterface

// File: rtl/matrix_result_drain.sv
// ----------------------------------------------------------------------------
// matrix_result_drain
// Captures one N x N result matrix from the multiplier in a single handshake
// and streams its elements out one per cycle in row-major order, each tagged
// with its address, a last marker and its overflow flag. A sticky overflow
// bit records whether any captured element overflowed.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   bus          matrix_result_drain_if.slave (input matrix + output stream)
//   done         one-cycle pulse after the last element is accepted
//   clr_ovf      clears ovf_sticky (a simultaneous overflowing capture wins)
//   ovf_sticky   set when a captured matrix had any overflow flag set
//   o_dbg_state  current FSM state (0 = IDLE, 1 = DRAIN)
// ----------------------------------------------------------------------------
module matrix_result_drain #(
   parameter int DW = 16,
   parameter int N  = 4,
   parameter int AW = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   matrix_result_drain_if.slave    bus,
   output logic                    done,
   input  logic                    clr_ovf,
   output logic                    ovf_sticky,
   output logic                    o_dbg_state
);

   localparam int              NE       = N * N;
   localparam logic [AW-1:0]   LAST_IDX = AW'(NE - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_DRAIN = 1'b1
   } state_t;

   state_t            r_state;
   logic [AW-1:0]     r_idx;
   logic [DW-1:0]     r_buf [NE];
   logic [NE-1:0]     r_ovf_buf;

   logic              r_in_ready;
   logic              r_out_valid;
   logic [DW-1:0]     r_out_data;
   logic [AW-1:0]     r_out_addr;
   logic              r_out_last;
   logic              r_out_ovf;
   logic              r_done;
   logic              r_ovf_sticky;

   logic              w_capture;
   logic              w_at_last;
   logic [AW-1:0]     w_idx_nxt;

   // in_ready is high exactly in IDLE, so the state alone qualifies a capture.
   assign w_capture = (r_state == S_IDLE) && bus.in_valid;
   assign w_at_last = (r_idx == LAST_IDX);
   assign w_idx_nxt = r_idx + 1'b1;

   // Buffer holds don't-care contents after reset and is written only at capture.
   always_ff @(posedge clk) begin
      if (w_capture) begin
         for (int k = 0; k < NE; k++) begin
            r_buf[k] <= bus.in_data[k*DW +: DW];
         end
         r_ovf_buf <= bus.in_ovf;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_idx        <= '0;
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_addr   <= '0;
         r_out_last   <= 1'b0;
         r_out_ovf    <= 1'b0;
         r_done       <= 1'b0;
         r_ovf_sticky <= 1'b0;
      end else begin
         r_done <= 1'b0;

         // Set has priority over clear when both land in the same cycle.
         if (w_capture && (|bus.in_ovf)) begin
            r_ovf_sticky <= 1'b1;
         end else if (clr_ovf) begin
            r_ovf_sticky <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  // Element 0 is taken straight from the input so it is
                  // presented the cycle after capture, while the buffer fills.
                  r_state     <= S_DRAIN;
                  r_idx       <= '0;
                  r_in_ready  <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_out_data  <= bus.in_data[0 +: DW];
                  r_out_addr  <= '0;
                  r_out_last  <= (NE == 1);
                  r_out_ovf   <= bus.in_ovf[0];
               end
            end
            S_DRAIN: begin
               if (bus.out_ready) begin
                  if (w_at_last) begin
                     r_state     <= S_IDLE;
                     r_idx       <= '0;
                     r_in_ready  <= 1'b1;
                     r_out_valid <= 1'b0;
                     r_out_data  <= '0;
                     r_out_addr  <= '0;
                     r_out_last  <= 1'b0;
                     r_out_ovf   <= 1'b0;
                     r_done      <= 1'b1;
                  end else begin
                     r_idx       <= w_idx_nxt;
                     r_out_data  <= r_buf[w_idx_nxt];
                     r_out_addr  <= w_idx_nxt;
                     r_out_last  <= (w_idx_nxt == LAST_IDX);
                     r_out_ovf   <= r_ovf_buf[w_idx_nxt];
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_addr  = r_out_addr;
   assign bus.out_last  = r_out_last;
   assign bus.out_ovf   = r_out_ovf;
   assign done          = r_done;
   assign ovf_sticky    = r_ovf_sticky;
   assign o_dbg_state   = r_state;

endmodule
